// File: rtl/modem_axi_ring_slave_if.sv
// modem_axi_ring_slave_if: AXI4-Lite bus bundle between the PS master and one modem channel slave
interface modem_axi_ring_slave_if #(
   parameter int AW = 13,
   parameter int DW = 32
);
   logic [AW-1:0]   awaddr;
   logic [2:0]      awprot;
   logic            awvalid;
   logic            awready;
   logic [DW-1:0]   wdata;
   logic [DW/8-1:0] wstrb;
   logic            wvalid;
   logic            wready;
   logic [1:0]      bresp;
   logic            bvalid;
   logic            bready;
   logic [AW-1:0]   araddr;
   logic [2:0]      arprot;
   logic            arvalid;
   logic            arready;
   logic [DW-1:0]   rdata;
   logic [1:0]      rresp;
   logic            rvalid;
   logic            rready;
   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/modem_axi_ring_slave.sv
// modem_axi_ring_slave: AXI4-Lite slave exposing TX/RX ring windows, pointer/level registers and a W1C interrupt
module modem_axi_ring_slave #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 13,
   parameter int PTR_WIDTH          = 8
) (
   input  logic                            S_AXI_ACLK,
   input  logic                            S_AXI_ARESETN,
   modem_axi_ring_slave_if.slave           s_axi,
   input  logic [PTR_WIDTH-1:0]            tx_rp_i,
   input  logic [PTR_WIDTH-1:0]            rx_wp_i,
   output logic [PTR_WIDTH-1:0]            tx_wp_o,
   output logic [PTR_WIDTH-1:0]            rx_rp_o,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   tx_wdata_o,
   output logic [C_S_AXI_DATA_WIDTH/8-1:0] tx_wstrb_o,
   output logic [PTR_WIDTH-1:0]            tx_waddr_o,
   output logic                            tx_wen_o,
   output logic [PTR_WIDTH-1:0]            rx_raddr_o,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   rx_rdata_i,
   output logic                            irq_o
);
   localparam int AI = C_S_AXI_ADDR_WIDTH - 2;
   localparam int P  = PTR_WIDTH;
   localparam int DW = C_S_AXI_DATA_WIDTH;
   localparam int SW = DW / 8;
   localparam logic [AI-4:0] REG_BASE = (AI-3)'(64);
   logic          r_aw_held, r_w_held, r_bvalid, r_tx_wen, r_ar_busy, r_rvalid, r_tx_nz, r_irq;
   logic [AI-1:0] r_awaddr, r_ar_idx;
   logic [DW-1:0] r_wdata, r_tx_wdata, r_rdata;
   logic [SW-1:0] r_wstrb, r_tx_wstrb;
   logic [1:0]    r_bresp, r_rresp, r_rpipe, r_status, r_irq_en;
   logic [P-1:0]  r_tx_wp, r_rx_rp, r_tx_waddr, r_raddr, r_rx_prev;
   logic          w_aw_hs, w_w_hs, w_do_wr, w_wwin, w_wreg, w_wok, w_ptr_en, w_rwin, w_rreg;
   logic [AI-1:0] w_waddr;
   logic [DW-1:0] w_wd, w_reg_rd;
   logic [SW-1:0] w_ws;
   logic [2:0]    w_wk;
   logic [1:0]    w_clr, w_set;
   logic [P-1:0]  w_tx_lvl, w_rx_lvl;
   assign s_axi.awready = ~r_aw_held & ~r_bvalid;
   assign s_axi.wready  = ~r_w_held & ~r_bvalid;
   assign s_axi.bvalid  = r_bvalid;
   assign s_axi.bresp   = r_bresp;
   assign s_axi.arready = ~r_ar_busy;
   assign s_axi.rvalid  = r_rvalid;
   assign s_axi.rdata   = r_rdata;
   assign s_axi.rresp   = r_rresp;
   assign tx_wp_o    = r_tx_wp;
   assign rx_rp_o    = r_rx_rp;
   assign tx_wdata_o = r_tx_wdata;
   assign tx_wstrb_o = r_tx_wstrb;
   assign tx_waddr_o = r_tx_waddr;
   assign tx_wen_o   = r_tx_wen;
   assign rx_raddr_o = r_raddr;
   assign irq_o      = r_irq;
   // A channel captured this edge counts as held, so AW+W together complete in one edge
   assign w_aw_hs  = s_axi.awvalid & s_axi.awready;
   assign w_w_hs   = s_axi.wvalid & s_axi.wready;
   assign w_do_wr  = (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);
   assign w_waddr  = r_aw_held ? r_awaddr : s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
   assign w_wd     = r_w_held ? r_wdata : s_axi.wdata;
   assign w_ws     = r_w_held ? r_wstrb : s_axi.wstrb;
   assign w_wk     = w_waddr[2:0];
   assign w_wwin   = w_waddr[AI-1:P] == '0;
   assign w_wreg   = w_waddr[AI-1:3] == REG_BASE;
   assign w_wok    = w_wwin | (w_wreg & (w_wk inside {3'd1, 3'd2, 3'd4, 3'd5}));
   assign w_ptr_en = w_do_wr & w_wreg & (w_ws[0] | w_ws[1]);
   assign w_clr    = (w_do_wr & w_wreg & (w_wk == 3'd4)) ? w_wd[1:0] : 2'b00;
   assign w_tx_lvl = r_tx_wp - tx_rp_i;
   assign w_rx_lvl = rx_wp_i - r_rx_rp;
   assign w_set    = {r_tx_nz & (w_tx_lvl == '0), rx_wp_i != r_rx_prev};
   assign w_rwin   = r_ar_idx[AI-1:P] == '0;
   assign w_rreg   = r_ar_idx[AI-1:3] == REG_BASE;
   always_comb begin
      w_reg_rd = '0;
      case (r_ar_idx[2:0])
         3'd0: w_reg_rd = DW'({tx_rp_i, 2'b00});
         3'd1: w_reg_rd = DW'({r_tx_wp, 2'b00});
         3'd2: w_reg_rd = DW'({r_rx_rp, 2'b00});
         3'd3: w_reg_rd = DW'({rx_wp_i, 2'b00});
         3'd4: w_reg_rd = DW'(r_status);
         3'd5: w_reg_rd = DW'(r_irq_en);
         3'd6: w_reg_rd = DW'(w_tx_lvl);
         3'd7: w_reg_rd = DW'(w_rx_lvl);
      endcase
   end
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_aw_held  <= 1'b0;
         r_w_held   <= 1'b0;
         r_awaddr   <= '0;
         r_wdata    <= '0;
         r_wstrb    <= '0;
         r_bvalid   <= 1'b0;
         r_bresp    <= 2'b00;
         r_tx_wen   <= 1'b0;
         r_tx_waddr <= '0;
         r_tx_wdata <= '0;
         r_tx_wstrb <= '0;
         r_tx_wp    <= '0;
         r_rx_rp    <= '0;
         r_irq_en   <= 2'b00;
      end else begin
         r_tx_wen <= w_do_wr & w_wwin;
         if (w_aw_hs & ~w_do_wr) begin
            r_aw_held <= 1'b1;
            r_awaddr  <= s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
         end
         if (w_w_hs & ~w_do_wr) begin
            r_w_held <= 1'b1;
            r_wdata  <= s_axi.wdata;
            r_wstrb  <= s_axi.wstrb;
         end
         if (w_do_wr) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_bvalid  <= 1'b1;
            r_bresp   <= w_wok ? 2'b00 : 2'b10;
         end else if (r_bvalid & s_axi.bready)
            r_bvalid <= 1'b0;
         if (w_do_wr & w_wwin) begin
            r_tx_waddr <= w_waddr[P-1:0];
            r_tx_wdata <= w_wd;
            r_tx_wstrb <= w_ws;
         end
         if (w_ptr_en & (w_wk == 3'd1)) r_tx_wp <= w_wd[P+1:2];
         if (w_ptr_en & (w_wk == 3'd2)) r_rx_rp <= w_wd[P+1:2];
         if (w_do_wr & w_wreg & (w_wk == 3'd5) & w_ws[0]) r_irq_en <= w_wd[1:0];
      end
   end
   // Two-stage read pipe: address out, synchronous RX memory, then RDATA capture
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_ar_busy <= 1'b0;
         r_ar_idx  <= '0;
         r_raddr   <= '0;
         r_rpipe   <= 2'b00;
         r_rvalid  <= 1'b0;
         r_rdata   <= '0;
         r_rresp   <= 2'b00;
      end else begin
         r_rpipe <= {r_rpipe[0], s_axi.arvalid & ~r_ar_busy};
         if (s_axi.arvalid & ~r_ar_busy) begin
            r_ar_busy <= 1'b1;
            r_ar_idx  <= s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2];
            r_raddr   <= s_axi.araddr[P+1:2];
         end
         if (r_rpipe[1]) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rwin ? rx_rdata_i : w_rreg ? w_reg_rd : '0;
            r_rresp  <= (w_rwin | w_rreg) ? 2'b00 : 2'b10;
         end else if (r_rvalid & s_axi.rready) begin
            r_rvalid  <= 1'b0;
            r_ar_busy <= 1'b0;
         end
      end
   end
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_status  <= 2'b00;
         r_rx_prev <= '0;
         r_tx_nz   <= 1'b0;
         r_irq     <= 1'b0;
      end else begin
         r_status  <= (r_status & ~w_clr) | w_set;
         r_rx_prev <= rx_wp_i;
         r_tx_nz   <= w_tx_lvl != '0;
         r_irq     <= |(r_status & r_irq_en);
      end
   end
endmodule

// File: tb/tb_modem_axi_ring_slave.sv
// tb_modem_axi_ring_slave: directed vectors with a B/R response scoreboard checked by a separate monitor
module tb_modem_axi_ring_slave;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  tx_rp_i = '0, rx_wp_i = '0;
   logic [7:0]  tx_wp_o, rx_rp_o, tx_waddr_o, rx_raddr_o;
   logic [31:0] tx_wdata_o, rx_rdata_i = '0;
   logic [3:0]  tx_wstrb_o;
   logic        tx_wen_o, irq_o;
   int          checks = 0, failures = 0;
   logic [1:0]  eb[$];
   logic [33:0] er[$];
   modem_axi_ring_slave_if #(.AW(13), .DW(32)) axi();
   modem_axi_ring_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(13), .PTR_WIDTH(8)) dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .s_axi(axi),
      .tx_rp_i(tx_rp_i), .rx_wp_i(rx_wp_i), .tx_wp_o(tx_wp_o), .rx_rp_o(rx_rp_o),
      .tx_wdata_o(tx_wdata_o), .tx_wstrb_o(tx_wstrb_o), .tx_waddr_o(tx_waddr_o), .tx_wen_o(tx_wen_o),
      .rx_raddr_o(rx_raddr_o), .rx_rdata_i(rx_rdata_i), .irq_o(irq_o)
   );
   always #5 clk = ~clk;
   // RX memory model: one-cycle synchronous read
   always @(posedge clk) rx_rdata_i <= (rx_raddr_o == 8'd3) ? 32'h1234_5678 : {24'hA5A5A5, rx_raddr_o};
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
      end
   endtask
   always @(negedge clk) begin : mon
      logic [33:0] e;
      if (rst_n && axi.bvalid && axi.bready) begin
         if (eb.size() == 0) begin
            checks++; failures++;
            $display("FAIL b_unexpected: got bresp 0x%0h with nothing expected", axi.bresp);
         end else chk("bresp", 32'(axi.bresp), 32'(eb.pop_front()));
      end
      if (rst_n && axi.rvalid && axi.rready) begin
         if (er.size() == 0) begin
            checks++; failures++;
            $display("FAIL r_unexpected: got rdata 0x%0h with nothing expected", axi.rdata);
         end else begin
            e = er.pop_front();
            chk("rdata", axi.rdata, e[31:0]);
            chk("rresp", 32'(axi.rresp), 32'(e[33:32]));
         end
      end
   end
   task automatic wait_rdy(input int ch);
      int n = 0;
      @(negedge clk);
      while (!(ch == 0 ? (axi.awready && axi.wready) : ch == 1 ? axi.wready : ch == 2 ? axi.awready : axi.arready) && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (n >= 50) begin
         checks++; failures++;
         $display("FAIL ready_timeout: channel %0d never ready, required within 50 cycles", ch);
      end
      @(posedge clk); #1;
   endtask
   task automatic wait_b();
      int n = 0;
      while (eb.size() != 0 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("b_drained", eb.size(), 0);
   endtask
   task automatic wait_r();
      int n = 0;
      while (er.size() != 0 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("r_drained", er.size(), 0);
   endtask
   task automatic wr(input logic [12:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] resp);
      eb.push_back(resp);
      axi.awaddr = a; axi.wdata = d; axi.wstrb = s;
      axi.awvalid = 1'b1; axi.wvalid = 1'b1;
      wait_rdy(0);
      axi.awvalid = 1'b0; axi.wvalid = 1'b0;
      wait_b();
   endtask
   task automatic rd(input logic [12:0] a, input logic [31:0] d, input logic [1:0] resp);
      er.push_back({resp, d});
      axi.araddr = a; axi.arvalid = 1'b1;
      wait_rdy(3);
      axi.arvalid = 1'b0;
      wait_r();
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end
   initial begin
      axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0;
      axi.bready = 1'b1; axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0; axi.rready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_awready", axi.awready, 1); chk("rst_wready", axi.wready, 1); chk("rst_arready", axi.arready, 1);
      chk("rst_bvalid", axi.bvalid, 0); chk("rst_rvalid", axi.rvalid, 0); chk("rst_wen", tx_wen_o, 0);
      chk("rst_irq", irq_o, 0); chk("rst_tx_wp", tx_wp_o, 0); chk("rst_rx_rp", rx_rp_o, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      // AW and W in the same cycle to a window address
      eb.push_back(2'b00);
      axi.awaddr = 13'h010; axi.wdata = 32'hDEAD_BEEF; axi.wstrb = 4'hF;
      axi.awvalid = 1'b1; axi.wvalid = 1'b1;
      wait_rdy(0);
      axi.awvalid = 1'b0; axi.wvalid = 1'b0;
      chk("win_wen", tx_wen_o, 1); chk("win_waddr", tx_waddr_o, 4); chk("win_wstrb", tx_wstrb_o, 4'hF);
      chk("win_wdata", tx_wdata_o, 32'hDEAD_BEEF); chk("win_bvalid", axi.bvalid, 1);
      @(posedge clk); #1;
      chk("win_wen_drop", tx_wen_o, 0);
      wait_b();
      // W two cycles ahead of AW, to TX_WP
      eb.push_back(2'b00);
      axi.wdata = 32'h0000_0028; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
      wait_rdy(1);
      axi.wvalid = 1'b0;
      chk("wfirst_wready", axi.wready, 0); chk("wfirst_awready", axi.awready, 1);
      @(posedge clk); #1;
      axi.awaddr = 13'h804; axi.awvalid = 1'b1;
      wait_rdy(2);
      axi.awvalid = 1'b0;
      chk("wfirst_bvalid", axi.bvalid, 1); chk("reg_no_wen", tx_wen_o, 0);
      wait_b();
      chk("tx_wp_10", tx_wp_o, 10);
      rd(13'h818, 32'd10, 2'b00);
      tx_rp_i = 8'd250;
      wr(13'h804, 32'h0000_0010, 4'hF, 2'b00);
      chk("tx_wp_4", tx_wp_o, 4);
      rd(13'h818, 32'd10, 2'b00);
      rd(13'h804, 32'h0000_0010, 2'b00);
      wr(13'h804, 32'h0000_03FC, 4'b1100, 2'b00);
      chk("tx_wp_strb_ignored", tx_wp_o, 4);
      // Read latency with RREADY held low
      axi.rready = 1'b0;
      er.push_back({2'b00, 32'h1234_5678});
      axi.araddr = 13'h00C; axi.arvalid = 1'b1;
      wait_rdy(3);
      axi.arvalid = 1'b0;
      chk("lat_arready", axi.arready, 0); chk("lat_raddr", rx_raddr_o, 3); chk("lat_rvalid_n1", axi.rvalid, 0);
      @(posedge clk); #1;
      chk("lat_rvalid_n1b", axi.rvalid, 0);
      @(posedge clk); #1;
      chk("lat_rvalid_n2", axi.rvalid, 1); chk("lat_rdata", axi.rdata, 32'h1234_5678);
      repeat (2) begin
         @(posedge clk); #1;
         chk("lat_rvalid_hold", axi.rvalid, 1); chk("lat_rdata_hold", axi.rdata, 32'h1234_5678);
         chk("lat_arready_hold", axi.arready, 0);
      end
      axi.rready = 1'b1;
      wait_r();
      chk("lat_arready_back", axi.arready, 1);
      // Error responses and map boundaries
      wr(13'h800, 32'h0000_0055, 4'hF, 2'b10);
      rd(13'h800, 32'h0000_03E8, 2'b00);
      rd(13'h900, 32'h0, 2'b10);
      rd(13'h400, 32'h0, 2'b10);
      rd(13'h3FC, 32'hA5A5_A5FF, 2'b00);
      wr(13'h81C, 32'h0000_0004, 4'hF, 2'b10);
      wr(13'h820, 32'h0000_0004, 4'hF, 2'b10);
      wr(13'h808, 32'h0000_000C, 4'hF, 2'b00);
      chk("rx_rp_3", rx_rp_o, 3);
      rd(13'h81C, 32'd253, 2'b00);
      rd(13'h80C, 32'h0, 2'b00);
      // Interrupt: new RX data, W1C racing a set, then a clean clear
      wr(13'h814, 32'h1, 4'hF, 2'b00);
      rx_wp_i = 8'd1;
      @(posedge clk); #1;
      chk("irq_n1", irq_o, 0);
      @(posedge clk); #1;
      chk("irq_n2", irq_o, 1);
      eb.push_back(2'b00);
      axi.awaddr = 13'h810; axi.wdata = 32'h1; axi.wstrb = 4'hF;
      axi.awvalid = 1'b1; axi.wvalid = 1'b1;
      rx_wp_i = 8'd2;
      wait_rdy(0);
      axi.awvalid = 1'b0; axi.wvalid = 1'b0;
      wait_b();
      @(posedge clk); #1;
      chk("irq_set_wins", irq_o, 1);
      rd(13'h810, 32'h1, 2'b00);
      wr(13'h810, 32'h1, 4'hF, 2'b00);
      chk("irq_cleared", irq_o, 0);
      rd(13'h810, 32'h0, 2'b00);
      tx_rp_i = 8'd4;
      repeat (2) @(posedge clk);
      #1;
      rd(13'h810, 32'h2, 2'b00);
      chk("irq_masked", irq_o, 0);
      // Reset with BVALID pending
      rx_wp_i = 8'd3;
      repeat (3) @(posedge clk);
      #1;
      chk("irq_before_rst", irq_o, 1);
      axi.bready = 1'b0;
      axi.awaddr = 13'h804; axi.wdata = 32'h0000_0014; axi.wstrb = 4'hF;
      axi.awvalid = 1'b1; axi.wvalid = 1'b1;
      wait_rdy(0);
      axi.awvalid = 1'b0; axi.wvalid = 1'b0;
      @(posedge clk); #1;
      chk("pend_bvalid", axi.bvalid, 1); chk("pend_tx_wp", tx_wp_o, 5);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_bvalid", axi.bvalid, 0); chk("arst_irq", irq_o, 0); chk("arst_tx_wp", tx_wp_o, 0);
      #20 rst_n = 1'b1;
      axi.bready = 1'b1;
      @(posedge clk); #1;
      chk("post_awready", axi.awready, 1); chk("post_wready", axi.wready, 1); chk("post_arready", axi.arready, 1);
      rd(13'h804, 32'h0, 2'b00);
      chk("eb_empty", eb.size(), 0);
      chk("er_empty", er.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
